// File: rtl/ibex_rf_wb_pkg.sv
// Shared types and helpers for the register-file write-back buffer.
// Entry data width is fixed at WbDataWidth; the buffer's DataWidth must match it.
package ibex_rf_wb_pkg;

  localparam int unsigned WbDataWidth = 32;

  typedef enum logic [1:0] {
    WB_IDLE,
    WB_DRAIN,
    WB_FLUSH
  } wb_state_e;

  typedef struct packed {
    logic                   valid;
    logic [4:0]             addr;
    logic [WbDataWidth-1:0] data;
  } wb_entry_t;

  // Pointers are at most 3 bits wide (Depth <= 8); callers cast to their own width.
  function automatic logic [2:0] wb_ptr_inc(input logic [2:0] ptr, input int unsigned depth);
    return (32'(ptr) == depth - 1) ? 3'd0 : ptr + 3'd1;
  endfunction

endpackage

// File: rtl/ibex_rf_wb_fwd_mux.sv
// Youngest-match forwarding mux over the write-back buffer entries.
// Scans oldest to youngest from the read pointer so later matches override earlier ones.
module ibex_rf_wb_fwd_mux
  import ibex_rf_wb_pkg::*;
#(
  parameter int unsigned Depth = 4,
  localparam int unsigned PtrW = $clog2(Depth)
) (
  input  wb_entry_t              entries [Depth],
  input  logic [PtrW-1:0]        rd_ptr,
  input  logic [4:0]             raddr,
  output logic                   valid,
  output logic [WbDataWidth-1:0] data
);

  logic [PtrW-1:0] idx;

  // NOTE: every output gets a default before the loop so no latch is inferred.
  always_comb begin
    valid = 1'b0;
    data  = '0;
    idx   = '0;
    for (int unsigned k = 0; k < Depth; k++) begin
      idx = rd_ptr + PtrW'(k);
      if (entries[idx].valid && (entries[idx].addr == raddr) && (raddr != 5'd0)) begin
        valid = 1'b1;
        data  = entries[idx].data;
      end
    end
  end

endmodule

// File: rtl/ibex_rf_wb_buffer.sv
// Write-back buffer in front of the hierarchical register file: absorbs writes during
// rf stalls, drains in order, forwards pending data. Optional: IBEX_RF_WB_COALESCE_EN.
module ibex_rf_wb_buffer
  import ibex_rf_wb_pkg::*;
#(
  parameter int unsigned Depth     = 4,
  parameter int unsigned DataWidth = WbDataWidth
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     wb_we_i,
  input  logic [4:0]               wb_waddr_i,
  input  logic [DataWidth-1:0]     wb_wdata_i,
  output logic                     wb_ready_o,
  output logic                     rf_we_o,
  output logic [4:0]               rf_waddr_o,
  output logic [DataWidth-1:0]     rf_wdata_o,
  input  logic                     rf_stall_i,
  input  logic [4:0]               raddr_a_i,
  input  logic [4:0]               raddr_b_i,
  output logic                     fwd_a_valid_o,
  output logic [DataWidth-1:0]     fwd_a_data_o,
  output logic                     fwd_b_valid_o,
  output logic [DataWidth-1:0]     fwd_b_data_o,
  input  logic                     flush_req_i,
  output logic                     flush_done_o,
  output logic [$clog2(Depth):0]   count_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = $clog2(Depth) + 1;

  wb_entry_t       entries [Depth];
  logic [PtrW-1:0] rd_ptr;
  logic [PtrW-1:0] wr_ptr;
  logic [CntW-1:0] count;
  logic [CntW-1:0] count_next;
  wb_state_e       state;

  logic push;
  logic alloc;
  logic pop;
  logic coal_hit;

`ifdef IBEX_RF_WB_COALESCE_EN
  logic [PtrW-1:0] coal_idx;
  logic [PtrW-1:0] scan_idx;

  // The head is skipped: it may be mid-write to the register file.
  always_comb begin
    coal_hit = 1'b0;
    coal_idx = '0;
    scan_idx = '0;
    for (int unsigned k = 1; k < Depth; k++) begin
      scan_idx = rd_ptr + PtrW'(k);
      if (entries[scan_idx].valid && (entries[scan_idx].addr == wb_waddr_i)) begin
        coal_hit = 1'b1;
        coal_idx = scan_idx;
      end
    end
  end
`else
  assign coal_hit = 1'b0;
`endif

  assign wb_ready_o = (state != WB_FLUSH) && ((count < CntW'(Depth)) || coal_hit);
  assign push       = wb_we_i && wb_ready_o && (wb_waddr_i != 5'd0);
  assign alloc      = push && !coal_hit;
  assign pop        = rf_we_o && !rf_stall_i;
  assign count_next = count + CntW'(alloc) - CntW'(pop);

  assign rf_we_o    = (count != '0);
  assign rf_waddr_o = entries[rd_ptr].addr;
  assign rf_wdata_o = entries[rd_ptr].data;
  assign count_o    = count;

  // NOTE: the whole entry array is reset, not just the valid bits, because the head
  // fields drive rf_waddr_o/rf_wdata_o directly and must read as zero out of reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < Depth; i++) begin
        entries[i] <= '0;
      end
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every flop reading pre-edge values.
      if (pop) begin
        entries[rd_ptr].valid <= 1'b0;
        rd_ptr                <= PtrW'(wb_ptr_inc(3'(rd_ptr), Depth));
      end
      if (alloc) begin
        entries[wr_ptr] <= '{valid: 1'b1, addr: wb_waddr_i, data: wb_wdata_i};
        wr_ptr          <= PtrW'(wb_ptr_inc(3'(wr_ptr), Depth));
      end
`ifdef IBEX_RF_WB_COALESCE_EN
      else if (push) begin
        entries[coal_idx].data <= wb_wdata_i;
      end
`endif
      count <= count_next;
    end
  end

  // A flush completes on the edge where occupancy reaches zero; done is registered.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state        <= WB_IDLE;
      flush_done_o <= 1'b0;
    end else begin
      flush_done_o <= 1'b0;
      if (flush_req_i || (state == WB_FLUSH)) begin
        if (count_next == '0) begin
          state        <= WB_IDLE;
          flush_done_o <= 1'b1;
        end else begin
          state <= WB_FLUSH;
        end
      end else begin
        state <= (count_next == '0) ? WB_IDLE : WB_DRAIN;
      end
    end
  end

  ibex_rf_wb_fwd_mux #(.Depth(Depth)) u_fwd_a (
    .entries (entries),
    .rd_ptr  (rd_ptr),
    .raddr   (raddr_a_i),
    .valid   (fwd_a_valid_o),
    .data    (fwd_a_data_o)
  );

  ibex_rf_wb_fwd_mux #(.Depth(Depth)) u_fwd_b (
    .entries (entries),
    .rd_ptr  (rd_ptr),
    .raddr   (raddr_b_i),
    .valid   (fwd_b_valid_o),
    .data    (fwd_b_data_o)
  );

  wb_protocol_a : assert property (@(posedge clk_i) disable iff (!rst_ni) wb_we_i |-> wb_ready_o);

endmodule

// File: tb/tb_ibex_rf_wb_buffer.sv
// Bench for ibex_rf_wb_buffer: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_ibex_rf_wb_buffer;

  localparam int unsigned DEPTH = 4;

  logic        clk_i       = 1'b0;
  logic        rst_ni      = 1'b0;
  logic        wb_we_i     = 1'b0;
  logic [4:0]  wb_waddr_i  = '0;
  logic [31:0] wb_wdata_i  = '0;
  logic        rf_stall_i  = 1'b0;
  logic [4:0]  raddr_a_i   = '0;
  logic [4:0]  raddr_b_i   = '0;
  logic        flush_req_i = 1'b0;

  logic        wb_ready_o;
  logic        rf_we_o;
  logic [4:0]  rf_waddr_o;
  logic [31:0] rf_wdata_o;
  logic        fwd_a_valid_o;
  logic [31:0] fwd_a_data_o;
  logic        fwd_b_valid_o;
  logic [31:0] fwd_b_data_o;
  logic        flush_done_o;
  logic [2:0]  count_o;

  always #5 clk_i = ~clk_i;

  ibex_rf_wb_buffer #(.Depth(DEPTH), .DataWidth(32)) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .wb_we_i       (wb_we_i),
    .wb_waddr_i    (wb_waddr_i),
    .wb_wdata_i    (wb_wdata_i),
    .wb_ready_o    (wb_ready_o),
    .rf_we_o       (rf_we_o),
    .rf_waddr_o    (rf_waddr_o),
    .rf_wdata_o    (rf_wdata_o),
    .rf_stall_i    (rf_stall_i),
    .raddr_a_i     (raddr_a_i),
    .raddr_b_i     (raddr_b_i),
    .fwd_a_valid_o (fwd_a_valid_o),
    .fwd_a_data_o  (fwd_a_data_o),
    .fwd_b_valid_o (fwd_b_valid_o),
    .fwd_b_data_o  (fwd_b_data_o),
    .flush_req_i   (flush_req_i),
    .flush_done_o  (flush_done_o),
    .count_o       (count_o)
  );

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pending writes in arrival order, plus flush bookkeeping.
  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t mq[$];
  bit  m_flush = 1'b0;
  bit  m_done  = 1'b0;

  function automatic int coal_slot(input logic [4:0] a);
    int slot = -1;
    if (a == 5'd0) return -1;
`ifdef IBEX_RF_WB_COALESCE_EN
    for (int i = 1; i < mq.size(); i++) begin
      if (mq[i].addr == a) slot = i;
    end
`endif
    return slot;
  endfunction

  function automatic bit m_ready();
    return !m_flush && ((mq.size() < DEPTH) || (coal_slot(wb_waddr_i) >= 0));
  endfunction

  function automatic logic [32:0] m_fwd(input logic [4:0] ra);
    if (ra == 5'd0) return '0;
    for (int i = mq.size() - 1; i >= 0; i--) begin
      if (mq[i].addr == ra) return {1'b1, mq[i].data};
    end
    return '0;
  endfunction

  initial begin
    forever begin
      @(posedge clk_i or negedge rst_ni);
      if (!rst_ni) begin
        mq.delete();
        m_flush = 1'b0;
        m_done  = 1'b0;
      end else begin
        bit do_push;
        bit do_pop;
        int slot;
        do_push = wb_we_i && m_ready() && (wb_waddr_i != 5'd0);
        do_pop  = (mq.size() != 0) && !rf_stall_i;
        slot    = coal_slot(wb_waddr_i);
        if (do_push && slot >= 0) mq[slot].data = wb_wdata_i;
        if (do_pop) void'(mq.pop_front());
        if (do_push && slot < 0) mq.push_back('{addr: wb_waddr_i, data: wb_wdata_i});
        m_done = 1'b0;
        if (flush_req_i || m_flush) begin
          if (mq.size() == 0) begin
            m_done  = 1'b1;
            m_flush = 1'b0;
          end else begin
            m_flush = 1'b1;
          end
        end
      end
    end
  end

  // Per-cycle comparison against the model, mid-cycle.
  initial begin
    logic [32:0] fa;
    logic [32:0] fb;
    forever begin
      @(negedge clk_i);
      fa = m_fwd(raddr_a_i);
      fb = m_fwd(raddr_b_i);
      check("m_ready", wb_ready_o, m_ready());
      check("m_rf_we", rf_we_o, mq.size() != 0);
      check("m_count", count_o, mq.size());
      check("m_flush_done", flush_done_o, m_done);
      check("m_fwd_a_valid", fwd_a_valid_o, fa[32]);
      check("m_fwd_a_data", fwd_a_data_o, fa[31:0]);
      check("m_fwd_b_valid", fwd_b_valid_o, fb[32]);
      check("m_fwd_b_data", fwd_b_data_o, fb[31:0]);
      if (mq.size() != 0) begin
        check("m_rf_waddr", rf_waddr_o, mq[0].addr);
        check("m_rf_wdata", rf_wdata_o, mq[0].data);
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push(input logic [4:0] a, input logic [31:0] d);
    wb_we_i    = 1'b1;
    wb_waddr_i = a;
    wb_wdata_i = d;
    tick();
    wb_we_i    = 1'b0;
  endtask

`ifdef IBEX_RF_WB_COALESCE_EN
  localparam int unsigned EXP_COAL_CNT = 2;
`else
  localparam int unsigned EXP_COAL_CNT = 3;
`endif

  initial begin
    int pulses;

    // Reset state
    repeat (2) @(negedge clk_i);
    check("rst_ready", wb_ready_o, 1);
    check("rst_rf_we", rf_we_o, 0);
    check("rst_count", count_o, 0);
    check("rst_done", flush_done_o, 0);
    check("rst_waddr", rf_waddr_o, 0);
    @(posedge clk_i);
    #1 rst_ni = 1'b1;
    tick();

    // Single write, visible next cycle, gone the cycle after
    push(5'd5, 32'hDEADBEEF);
    check("single_we", rf_we_o, 1);
    check("single_addr", rf_waddr_o, 5);
    check("single_data", rf_wdata_o, 32'hDEADBEEF);
    check("single_count", count_o, 1);
    tick();
    check("single_count_after", count_o, 0);
    check("single_we_after", rf_we_o, 0);

    // Fill under stall, then drain in order
    rf_stall_i = 1'b1;
    for (int i = 1; i <= 4; i++) push(5'(i), 32'(i * 'h11));
    raddr_a_i = 5'd3;
    raddr_b_i = 5'd1;
    #1;
    check("full_count", count_o, 4);
    check("full_ready", wb_ready_o, 0);
    check("full_fwd_a", fwd_a_data_o, 32'h33);
    check("full_fwd_b", fwd_b_data_o, 32'h11);
    rf_stall_i = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      check("drain_addr", rf_waddr_o, 5'(i));
      check("drain_data", rf_wdata_o, 32'(i * 'h11));
      tick();
    end
    check("drain_empty", count_o, 0);

    // Same register written twice while stalled: youngest value forwarded
    rf_stall_i = 1'b1;
    push(5'd9, 32'h99);
    push(5'd7, 32'hA);
    push(5'd7, 32'hB);
    raddr_a_i = 5'd7;
    raddr_b_i = 5'd9;
    #1;
    check("dup_fwd_valid", fwd_a_valid_o, 1);
    check("dup_fwd_data", fwd_a_data_o, 32'hB);
    check("dup_fwd_b", fwd_b_data_o, 32'h99);
    check("dup_count", count_o, EXP_COAL_CNT);
    rf_stall_i = 1'b0;
    repeat (3) tick();
    check("dup_drained", count_o, 0);

    // Write to x0 is dropped
    raddr_a_i = 5'd0;
    push(5'd0, 32'h123);
    check("x0_count", count_o, 0);
    check("x0_rf_we", rf_we_o, 0);
    check("x0_fwd", fwd_a_valid_o, 0);

    // Full buffer, flush with toggling stall
    rf_stall_i = 1'b1;
    for (int i = 0; i < 4; i++) push(5'(10 + i), 32'(32'hA0 + i));
    check("flush_full", count_o, 4);
    flush_req_i = 1'b1;
    tick();
    flush_req_i = 1'b0;
    check("flush_ready_low", wb_ready_o, 0);
    pulses = 0;
    for (int c = 0; c < 30; c++) begin
      rf_stall_i = c[0];
      tick();
      if (flush_done_o) begin
        pulses++;
        check("flush_done_count", count_o, 0);
      end
    end
    check("flush_pulses", pulses, 1);
    check("flush_ready_back", wb_ready_o, 1);

    // Reset with three pending entries
    rf_stall_i = 1'b1;
    push(5'd20, 32'h20);
    push(5'd21, 32'h21);
    push(5'd22, 32'h22);
    check("rst_pend_count", count_o, 3);
    #2 rst_ni = 1'b0;
    #1;
    check("rst_mid_we", rf_we_o, 0);
    check("rst_mid_count", count_o, 0);
    tick();
    rf_stall_i = 1'b0;
    rst_ni = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      check("post_rst_we", rf_we_o, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time %0t, expected end before 100000", $time);
    $fatal(1);
  end

endmodule
